// File: rtl/shift_job_sequencer.sv
// Round-robin job sequencer for the shared 8-bit multi-position shifter.
// Grants one of two requesters, loads the shifter, steps it cnt times, captures the result.
module shift_job_sequencer #(
  parameter int WIDTH = 8,
  parameter int NW    = 3,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic [NW-1:0]    n0,
  input  logic             r0,
  input  logic [CW-1:0]    cnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  input  logic [NW-1:0]    n1,
  input  logic             r1,
  input  logic [CW-1:0]    cnt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] sh_d,
  output logic [NW-1:0]    sh_n,
  output logic             sh_r,
  output logic             sh_load,
  input  logic [WIDTH-1:0] sh_w,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             owner,
  output logic             busy
);

  // state   | meaning
  // IDLE    | waiting for a request, grants combinationally
  // LOAD    | sh_load=1, shifter takes the job data
  // SHIFT   | shifter steps once per cycle, ctr counts remaining steps
  // CAPTURE | result takes sh_w, done pulses next cycle
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;

  state_t        state;
  logic          ptr;
  logic          pick1;
  logic [CW-1:0] ctr;

  // ptr=1 favours requester 1 when both are asking
  assign pick1 = req1 & (~req0 | ptr);
  assign gnt0  = ~rst & (state == IDLE) & req0 & ~pick1;
  assign gnt1  = ~rst & (state == IDLE) & pick1;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      ctr     <= '0;
      sh_d    <= '0;
      sh_n    <= '0;
      sh_r    <= 1'b0;
      sh_load <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      owner   <= 1'b0;
    end else begin
      done    <= 1'b0;
      sh_load <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            sh_d    <= pick1 ? d1 : d0;
            sh_n    <= pick1 ? n1 : n0;
            sh_r    <= pick1 ? r1 : r0;
            ctr     <= pick1 ? cnt1 : cnt0;
            owner   <= pick1;
            ptr     <= ~pick1;
            sh_load <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          state <= (ctr != '0) ? SHIFT : CAPTURE;
        end
        SHIFT: begin
          ctr <= ctr - 1'b1;
          if (ctr == CW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          result <= sh_w;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
